// File: rtl/pc_watch_pkg.sv
// Shared encodings for the PC watch / register dump monitor.
package pc_watch_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_BP       = 2'b01,
    CAUSE_LIMIT    = 2'b10,
    CAUSE_MISALIGN = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DUMP = 2'b10,
    S_DONE = 2'b11
  } state_e;

  // Captured PC and cycle count precede the register words.
  localparam int DUMP_HDR_WORDS = 2;

  function automatic int bp_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pc_watch_dump_if.sv
// Valid/ready stream carrying the halt snapshot out of the monitor.
interface pc_watch_dump_if #(
  parameter int DATA_W = 32
);
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;
  logic              dump_ready;

  modport master (
    output dump_valid,
    output dump_data,
    output dump_last,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_data,
    input  dump_last,
    output dump_ready
  );
endinterface

// File: rtl/pc_bp_match.sv
// Breakpoint slot registers with a parallel PC comparator.
module pc_bp_match
  import pc_watch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int NUM_BP = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        bp_we,
  input  logic [bp_idx_w(NUM_BP)-1:0] bp_idx,
  input  logic [ADDR_W-1:0]           bp_addr,
  input  logic                        bp_en,
  input  logic [ADDR_W-1:0]           pc,
  output logic                        bp_hit
);

  localparam int BP_IDX_W = bp_idx_w(NUM_BP);

  logic [ADDR_W-1:0] addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;
  logic [NUM_BP-1:0] match;

  // Slot decode compares against each legal index so out-of-range writes are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BP; i++) begin
        addr_q[i] <= '0;
      end
      en_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_we && (bp_idx == BP_IDX_W'(i))) begin
          addr_q[i] <= bp_addr;
          en_q[i]   <= bp_en;
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = en_q[i] && (addr_q[i] == pc);
    end
  end

  assign bp_hit = |match;

endmodule

// File: rtl/pc_watch_dump.sv
// Debug monitor: gates the CPU clock enable, halts on breakpoint / limit /
// misaligned PC, then streams PC, cycle count and the register file.
//
// state  | meaning
// S_IDLE | waiting for start, CPU held
// S_RUN  | CPU enabled until a halt condition is seen
// S_DUMP | streaming snapshot words, CPU held
// S_DONE | snapshot complete, halted; start re-arms
module pc_watch_dump
  import pc_watch_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_BP   = 4,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        start,
  input  logic                        bp_we,
  input  logic [bp_idx_w(NUM_BP)-1:0] bp_idx,
  input  logic [ADDR_W-1:0]           bp_addr,
  input  logic                        bp_en,
  input  logic [CNT_W-1:0]            cycle_limit,
  input  logic [ADDR_W-1:0]           pc,
  output logic                        cpu_en,
  output logic [4:0]                  reg_sel,
  input  logic [DATA_W-1:0]           reg_data,
  output logic                        halted,
  output logic [1:0]                  cause,
  output logic                        busy,
  pc_watch_dump_if.master             dump
);

  localparam int TOTAL = NUM_REGS + DUMP_HDR_WORDS;
  localparam int IDX_W = $clog2(TOTAL + 1);

  state_e            state;
  cause_e            cause_q;
  cause_e            hit_cause;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [ADDR_W-1:0] cap_pc;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  reg_idx;
  logic [DATA_W-1:0] next_word;
  logic              bp_hit;
  logic              misaligned;
  logic              limit_hit;
  logic              hit;
  logic              load;
  logic              last_hs;

  pc_bp_match #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp_match (
    .clk     (clk),
    .rstn    (rstn),
    .bp_we   (bp_we),
    .bp_idx  (bp_idx),
    .bp_addr (bp_addr),
    .bp_en   (bp_en),
    .pc      (pc),
    .bp_hit  (bp_hit)
  );

  assign misaligned = (pc[1:0] != 2'b00);
  assign limit_hit  = (cycle_limit != '0) && (cycle_cnt == cycle_limit);
  assign hit        = misaligned || bp_hit || limit_hit;

  // Combinational so the hitting instruction is never committed.
  assign cpu_en = (state == S_RUN) && !hit;

  assign load    = !dump.dump_valid || dump.dump_ready;
  assign last_hs = dump.dump_valid && dump.dump_ready && dump.dump_last;

  // reg_sel points at the register whose word is loaded on the coming edge.
  assign reg_idx = idx - IDX_W'(DUMP_HDR_WORDS);
  assign reg_sel = ((state == S_DUMP) && (idx >= IDX_W'(DUMP_HDR_WORDS)) && (idx < IDX_W'(TOTAL)))
                   ? 5'(reg_idx) : 5'd0;

  always_comb begin
    hit_cause = CAUSE_LIMIT;
    if (misaligned) begin
      hit_cause = CAUSE_MISALIGN;
    end else if (bp_hit) begin
      hit_cause = CAUSE_BP;
    end
  end

  always_comb begin
    next_word = reg_data;
    if (idx == IDX_W'(0)) begin
      next_word = DATA_W'(cap_pc);
    end else if (idx == IDX_W'(1)) begin
      next_word = DATA_W'(cycle_cnt);
    end
  end

  assign cause = cause_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= S_IDLE;
      cause_q         <= CAUSE_NONE;
      cycle_cnt       <= '0;
      cap_pc          <= '0;
      idx             <= '0;
      halted          <= 1'b0;
      busy            <= 1'b0;
      dump.dump_valid <= 1'b0;
      dump.dump_data  <= '0;
      dump.dump_last  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            cycle_cnt <= '0;
            cause_q   <= CAUSE_NONE;
            halted    <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_RUN: begin
          if (hit) begin
            state   <= S_DUMP;
            cap_pc  <= pc;
            cause_q <= hit_cause;
            idx     <= '0;
            halted  <= 1'b1;
          end else if (cycle_cnt != '1) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end
        S_DUMP: begin
          if (last_hs) begin
            state           <= S_DONE;
            busy            <= 1'b0;
            dump.dump_valid <= 1'b0;
            dump.dump_last  <= 1'b0;
          end else if (load && (idx < IDX_W'(TOTAL))) begin
            dump.dump_valid <= 1'b1;
            dump.dump_data  <= next_word;
            dump.dump_last  <= (idx == IDX_W'(TOTAL - 1));
            idx             <= idx + IDX_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_watch_dump.sv
// Directed bench for pc_watch_dump with a looping CPU model and register file.
module tb_pc_watch_dump;
  import pc_watch_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic        bp_we;
  logic [1:0]  bp_idx;
  logic [31:0] bp_addr;
  logic        bp_en;
  logic [31:0] cycle_limit;
  logic [31:0] pc;
  logic        cpu_en;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic        halted;
  logic [1:0]  cause;
  logic        busy;

  logic [31:0] cpu_pc;
  logic        cpu_restart;
  logic        pc_ovr_en;
  logic [31:0] pc_ovr;

  int checks = 0;
  int errors = 0;

  int          en_cnt;
  logic [31:0] hit_pc;
  logic [31:0] words [64];
  logic        lasts [64];
  int          n_words;
  int          first_k;
  int          last_k;

  always #5 clk = ~clk;

  pc_watch_dump_if #(.DATA_W(32)) dif ();

  pc_watch_dump dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .bp_we       (bp_we),
    .bp_idx      (bp_idx),
    .bp_addr     (bp_addr),
    .bp_en       (bp_en),
    .cycle_limit (cycle_limit),
    .pc          (pc),
    .cpu_en      (cpu_en),
    .reg_sel     (reg_sel),
    .reg_data    (reg_data),
    .halted      (halted),
    .cause       (cause),
    .busy        (busy),
    .dump        (dif)
  );

  function automatic logic [31:0] rf_val(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0103);
  endfunction

  // CPU loop program: pc steps by 4 through 0x00..0xFC and wraps.
  always @(posedge clk or negedge rstn) begin
    if (!rstn)            cpu_pc <= 32'h0;
    else if (cpu_restart) cpu_pc <= 32'h0;
    else if (cpu_en)      cpu_pc <= (cpu_pc + 32'd4) & 32'hFF;
  end

  assign pc       = pc_ovr_en ? pc_ovr : cpu_pc;
  assign reg_data = rf_val(int'(reg_sel));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bp_write(input int idx, input logic [31:0] addr, input logic en);
    bp_we   = 1'b1;
    bp_idx  = 2'(idx);
    bp_addr = addr;
    bp_en   = en;
    @(negedge clk);
    bp_we   = 1'b0;
  endtask

  task automatic start_run(input logic restart);
    start       = 1'b1;
    cpu_restart = restart;
    @(negedge clk);
    start       = 1'b0;
    cpu_restart = 1'b0;
  endtask

  task automatic run_until_halt(input int budget, input bit inject);
    bit seen;
    bit inj_done;
    seen     = 1'b0;
    inj_done = 1'b0;
    en_cnt   = 0;
    hit_pc   = 32'hDEAD_BEEF;
    for (int k = 0; k < budget; k++) begin
      if (halted) begin
        seen = 1'b1;
        break;
      end
      if (cpu_en) en_cnt++;
      else        hit_pc = pc;
      start = 1'b0;
      if (inject && !inj_done && en_cnt == 500) begin
        start    = 1'b1;
        inj_done = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) check("halt_timeout", 64'd0, 64'd1);
  endtask

  task automatic collect_dump(input bit bp_mode);
    logic [31:0] prev_data;
    logic        rdy;
    bit          stall;
    bit          done;
    logic [3:0]  pat;
    pat      = 4'b1001;
    stall    = 1'b0;
    done     = 1'b0;
    n_words  = 0;
    first_k  = -1;
    last_k   = -1;
    prev_data = '0;
    for (int k = 0; k < 400 && !done; k++) begin
      if (stall) begin
        check("stall_valid", 64'(dif.dump_valid), 64'd1);
        check("stall_data", 64'(dif.dump_data), 64'(prev_data));
      end
      rdy = bp_mode ? pat[k % 4] : 1'b1;
      dif.dump_ready = rdy;
      if (dif.dump_valid) begin
        if (first_k < 0) first_k = k;
        if (rdy) begin
          words[n_words] = dif.dump_data;
          lasts[n_words] = dif.dump_last;
          n_words++;
          last_k = k;
          if (dif.dump_last || n_words >= 64) done = 1'b1;
        end
      end
      stall     = dif.dump_valid && !rdy;
      prev_data = dif.dump_data;
      @(negedge clk);
    end
    if (!done) check("dump_timeout", 64'd0, 64'd1);
  endtask

  task automatic verify_dump(input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    int n_last;
    check("dump_words", 64'(n_words), 64'd34);
    if (n_words == 34) begin
      check("word0_pc", 64'(words[0]), 64'(exp_pc));
      check("word1_cnt", 64'(words[1]), 64'(exp_cnt));
      for (int i = 0; i < 32; i++) begin
        check($sformatf("rf%0d", i), 64'(words[i + 2]), 64'(rf_val(i)));
      end
      n_last = 0;
      for (int i = 0; i < 34; i++) if (lasts[i]) n_last++;
      check("last_count", 64'(n_last), 64'd1);
      check("last_on_final", 64'(lasts[33]), 64'd1);
    end
    check("done_halted", 64'(halted), 64'd1);
    check("done_busy", 64'(busy), 64'd0);
    check("done_valid", 64'(dif.dump_valid), 64'd0);
  endtask

  initial begin
    int hs;
    rstn           = 1'b0;
    start          = 1'b0;
    bp_we          = 1'b0;
    bp_idx         = '0;
    bp_addr        = '0;
    bp_en          = 1'b0;
    cycle_limit    = '0;
    cpu_restart    = 1'b0;
    pc_ovr_en      = 1'b0;
    pc_ovr         = '0;
    dif.dump_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cpu_en", 64'(cpu_en), 64'd0);
    check("rst_valid", 64'(dif.dump_valid), 64'd0);
    check("rst_data", 64'(dif.dump_data), 64'd0);
    check("rst_last", 64'(dif.dump_last), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_reg_sel", 64'(reg_sel), 64'd0);
    check("rst_cause", 64'(cause), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Breakpoint at 0x48: 18 committed instructions before the halt.
    bp_write(0, 32'h48, 1'b1);
    cycle_limit = 32'd0;
    start_run(1'b1);
    run_until_halt(200, 1'b0);
    check("bp_en_cnt", 64'(en_cnt), 64'd18);
    check("bp_hit_pc", 64'(hit_pc), 64'h48);
    check("bp_cause", 64'(cause), 64'(CAUSE_BP));
    check("bp_busy", 64'(busy), 64'd1);
    collect_dump(1'b0);
    check("first_word_lat", 64'(first_k), 64'd1);
    check("dump_span", 64'(last_k - first_k + 1), 64'd34);
    verify_dump(32'h48, 32'd18);

    // Re-arm from DONE with the CPU still sitting on the breakpoint.
    start_run(1'b0);
    check("rearm_cause", 64'(cause), 64'(CAUSE_NONE));
    check("rearm_busy", 64'(busy), 64'd1);
    check("rearm_halted", 64'(halted), 64'd0);
    check("rearm_cpu_en", 64'(cpu_en), 64'd0);
    run_until_halt(50, 1'b0);
    check("rearm_en_cnt", 64'(en_cnt), 64'd0);
    check("rearm_hit_cause", 64'(cause), 64'(CAUSE_BP));
    collect_dump(1'b1);
    verify_dump(32'h48, 32'd0);

    // Breakpoint and limit on the same cycle: breakpoint wins.
    bp_write(0, 32'h48, 1'b0);
    bp_write(1, 32'h10, 1'b1);
    cycle_limit = 32'd4;
    start_run(1'b1);
    run_until_halt(100, 1'b0);
    check("prio_en_cnt", 64'(en_cnt), 64'd4);
    check("prio_cause", 64'(cause), 64'(CAUSE_BP));
    collect_dump(1'b0);
    verify_dump(32'h10, 32'd4);

    // Limit of 1000 with a stray start mid-run.
    bp_write(1, 32'h10, 1'b0);
    cycle_limit = 32'd1000;
    start_run(1'b1);
    run_until_halt(2000, 1'b1);
    check("lim_en_cnt", 64'(en_cnt), 64'd1000);
    check("lim_cause", 64'(cause), 64'(CAUSE_LIMIT));
    collect_dump(1'b0);
    verify_dump(32'hA0, 32'h3E8);

    // Misaligned PC halts immediately.
    cycle_limit = 32'd0;
    pc_ovr_en   = 1'b1;
    pc_ovr      = 32'h0000_000A;
    start_run(1'b0);
    run_until_halt(20, 1'b0);
    check("mis_en_cnt", 64'(en_cnt), 64'd0);
    check("mis_cause", 64'(cause), 64'(CAUSE_MISALIGN));
    collect_dump(1'b1);
    verify_dump(32'h0A, 32'd0);
    pc_ovr_en = 1'b0;

    // Reset in the middle of a dump, then a fresh run with breakpoints cleared.
    bp_write(0, 32'h48, 1'b1);
    start_run(1'b1);
    run_until_halt(200, 1'b0);
    dif.dump_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 100 && hs < 5; k++) begin
      if (dif.dump_valid) hs++;
      @(negedge clk);
    end
    check("mid_words", 64'(hs), 64'd5);
    rstn = 1'b0;
    #1;
    check("mid_rst_cpu_en", 64'(cpu_en), 64'd0);
    check("mid_rst_valid", 64'(dif.dump_valid), 64'd0);
    check("mid_rst_data", 64'(dif.dump_data), 64'd0);
    check("mid_rst_last", 64'(dif.dump_last), 64'd0);
    check("mid_rst_halted", 64'(halted), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_reg_sel", 64'(reg_sel), 64'd0);
    check("mid_rst_cause", 64'(cause), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    cycle_limit = 32'd30;
    start_run(1'b1);
    run_until_halt(200, 1'b0);
    check("post_rst_en_cnt", 64'(en_cnt), 64'd30);
    check("post_rst_cause", 64'(cause), 64'(CAUSE_LIMIT));
    collect_dump(1'b0);
    verify_dump(32'h78, 32'd30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
